// File: rtl/pc_stack_if.sv
// Command/status bundle between the control FSM and the program counter.
// Signal suffixes are named from the program counter's point of view.
interface pc_stack_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned OW = 5
) ();
    logic          up_i;
    logic          load_i;
    logic          branch_i;
    logic          call_i;
    logic          ret_i;
    logic [AW-1:0] target_i;
    logic [OW-1:0] offset_i;
    logic [AW-1:0] mem_addr_o;
    logic          stk_empty_o;
    logic          stk_full_o;
    logic          stk_err_o;

    modport master (
        output up_i, load_i, branch_i, call_i, ret_i, target_i, offset_i,
        input  mem_addr_o, stk_empty_o, stk_full_o, stk_err_o
    );

    modport slave (
        input  up_i, load_i, branch_i, call_i, ret_i, target_i, offset_i,
        output mem_addr_o, stk_empty_o, stk_full_o, stk_err_o
    );
endinterface

// File: rtl/pc_stack.sv
// Program counter with absolute jump, signed relative branch and a
// return-address stack for call/return; one command per clock, Call > Ret > Load > Branch > Up.
module pc_stack #(
    parameter int unsigned   AW          = 7,
    parameter int unsigned   OW          = 5,
    parameter int unsigned   STACK_DEPTH = 4,
    parameter logic [AW-1:0] RESET_ADDR  = '0
) (
    input  logic       clk,
    input  logic       clr,
    pc_stack_if.slave  bus
);
    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [AW-1:0] stack_q [STACK_DEPTH];
    logic [AW-1:0] stack_d [STACK_DEPTH];

    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_branch;

    // Push slot is the current count; top of stack sits one below it.
    assign wr_idx    = IW'(cnt_q);
    assign rd_idx    = IW'(cnt_q - CW'(1));
    assign pc_inc    = pc_q + AW'(1);
    assign pc_branch = pc_q + AW'($signed(bus.offset_i));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q    <= RESET_ADDR;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            stack_q <= '{default: '0};
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            stack_q <= stack_d;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stack_d = stack_q;

        if (bus.call_i) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                stack_d[wr_idx] = pc_inc;
                cnt_d           = cnt_q + CW'(1);
                pc_d            = bus.target_i;
            end
        end else if (bus.ret_i) begin
            if (empty_q) begin
                err_d = 1'b1;
            end else begin
                pc_d  = stack_q[rd_idx];
                cnt_d = cnt_q - CW'(1);
            end
        end else if (bus.load_i) begin
            pc_d = bus.target_i;
        end else if (bus.branch_i) begin
            pc_d = pc_branch;
        end else if (bus.up_i) begin
            pc_d = pc_inc;
        end

        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CW'(STACK_DEPTH));
    end

    assign bus.mem_addr_o  = pc_q;
    assign bus.stk_empty_o = empty_q;
    assign bus.stk_full_o  = full_q;
    assign bus.stk_err_o   = err_q;
endmodule
